// File: rtl/barrel_shift_pkg.sv
// -----------------------------------------------------------------------------
// barrel_shift_pkg
// Shared encodings for the pipelined barrel shifter.
//   mode_e     : operation select carried down the pipeline with each word
//   DIR_LEFT   : control value selecting a left shift
//   DIR_RIGHT  : control value selecting a right shift
// -----------------------------------------------------------------------------
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        MODE_LOG = 2'b00,   // logical, zero fill
        MODE_ARI = 2'b01,   // arithmetic (sign fill on right shifts)
        MODE_ROT = 2'b10,   // rotate (only with BARREL_ROTATE_EN)
        MODE_RSV = 2'b11    // reserved, treated as logical
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shift_stage.sv
// -----------------------------------------------------------------------------
// barrel_shift_stage
// One pipeline stage of the barrel shifter: a fixed shift by AMT positions,
// applied when the lowest remaining shift-amount bit is set, followed by the
// stage register. The register only loads while adv is high, so a stalled
// pipeline holds every word in place.
//
// Build option: define BARREL_ROTATE_EN to include the rotate wrap path for
// MODE_ROT. Without it MODE_ROT falls back to a logical shift and the wrap
// muxing is not present.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   adv            : pipeline advance (register load enable)
//   valid_in/out   : word-present flag
//   data_in/out    : operand / partially shifted operand
//   mag_in/out     : remaining shift-amount bits; bit 0 belongs to this stage,
//                    the output is shifted down one place for the next stage
//   control_in/out : direction, DIR_LEFT / DIR_RIGHT
//   mode_in/out    : operation, see mode_e
// -----------------------------------------------------------------------------
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adv,
    input  logic                     valid_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] mag_in,
    input  logic                     control_in,
    input  logic [1:0]               mode_in,
    output logic                     valid_out,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(WIDTH)-1:0] mag_out,
    output logic                     control_out,
    output logic [1:0]               mode_out
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] data_next;
    logic             fill;

    always_comb begin
        // Earlier stages never disturb the MSB on an arithmetic right shift,
        // so the current MSB is still the operand's sign bit.
        fill = (mode_in == MODE_ARI) ? data_in[WIDTH-1] : 1'b0;

        if (control_in == DIR_LEFT) begin
            shifted = data_in << AMT;
        end else begin
            shifted = {{AMT{fill}}, data_in[WIDTH-1:AMT]};
        end

`ifdef BARREL_ROTATE_EN
        if (mode_in == MODE_ROT) begin
            if (control_in == DIR_LEFT) begin
                shifted = {data_in[WIDTH-AMT-1:0], data_in[WIDTH-1:WIDTH-AMT]};
            end else begin
                shifted = {data_in[AMT-1:0], data_in[WIDTH-1:AMT]};
            end
        end
`endif

        data_next = mag_in[0] ? shifted : data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            data_out    <= '0;
            mag_out     <= '0;
            control_out <= 1'b0;
            mode_out    <= 2'b00;
        end else if (adv) begin
            valid_out   <= valid_in;
            data_out    <= data_next;
            mag_out     <= mag_in >> 1;
            control_out <= control_in;
            mode_out    <= mode_in;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
// Log2(WIDTH)-stage pipelined barrel shifter with valid/ready handshaking.
// Stage k shifts by 2^k when shift_mag bit k is set. The whole pipeline moves
// together on adv = !out_valid || out_ready; a word that cannot leave the last
// stage freezes every stage, and in_ready drops in the same cycle.
//
// Build option: BARREL_ROTATE_EN enables rotate for mode 2'b10; otherwise that
// mode behaves as a logical shift.
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : input handshake
//   in_data            : operand
//   shift_mag          : shift amount, 0..WIDTH-1
//   control            : 0 = left, 1 = right
//   mode               : 00 logical, 01 arithmetic, 10 rotate, 11 logical
//   out_valid/out_ready: output handshake
//   out_data           : shifted result
//   out_zero           : out_data is all zeros (meaningful while out_valid)
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
    import barrel_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   shift_mag,
    input  logic             control,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    // Element 0 is the input side, element SHW the last stage register.
    logic [SHW:0]       valid_chain;
    logic [SHW:0]       control_chain;
    logic [WIDTH-1:0]   data_chain [0:SHW];
    logic [SHW-1:0]     mag_chain  [0:SHW];
    logic [1:0]         mode_chain [0:SHW];
    logic               adv;
    logic               unused_tail;

    assign adv      = !valid_chain[SHW] || out_ready;
    assign in_ready = adv;

    // A cycle with adv high and no input loads a bubble into stage 0.
    assign valid_chain[0]   = in_valid;
    assign data_chain[0]    = in_data;
    assign mag_chain[0]     = shift_mag;
    assign control_chain[0] = control;
    assign mode_chain[0]    = mode;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            barrel_shift_stage #(
                .WIDTH (WIDTH),
                .AMT   (1 << gi)
            ) u_stage (
                .clk         (clk),
                .rst_n       (rst_n),
                .adv         (adv),
                .valid_in    (valid_chain[gi]),
                .data_in     (data_chain[gi]),
                .mag_in      (mag_chain[gi]),
                .control_in  (control_chain[gi]),
                .mode_in     (mode_chain[gi]),
                .valid_out   (valid_chain[gi+1]),
                .data_out    (data_chain[gi+1]),
                .mag_out     (mag_chain[gi+1]),
                .control_out (control_chain[gi+1]),
                .mode_out    (mode_chain[gi+1])
            );
        end
    endgenerate

    // Side-band fields have no consumer after the last stage.
    assign unused_tail = ^{mag_chain[SHW], control_chain[SHW], mode_chain[SHW]};

    assign out_valid = valid_chain[SHW];
    assign out_data  = data_chain[SHW];
    // Decoded straight from the last stage register, so it changes only when
    // out_data does; gated by valid so it reads 0 in reset and on bubbles.
    assign out_zero  = valid_chain[SHW] && (data_chain[SHW] == '0);

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the data width; it must be a power of two, 4..64.
REQ-002 The localparam SHW SHALL equal log2(WIDTH) and set the shift-amount width; with WIDTH=8, SHW=3.
REQ-003 The ports SHALL be, in order:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word offered.
- in_ready  output  1  block can accept the input word.
- in_data  input  WIDTH  operand.
- shift_mag  input  SHW  shift amount, 0..WIDTH-1.
- control  input  1  direction: 0 = left, 1 = right.
- mode  input  2  operation: 00 logical, 01 arithmetic, 10 rotate, 11 reserved.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted result.
- out_zero  output  1  out_data is all zeros.

Function
REQ-004 The block SHALL be a pipeline of SHW stages; stage k shifts by 2^k when shift_mag bit k is 1, in order k = 0 .. SHW-1.
REQ-005 Each stage SHALL register its data, valid bit, remaining shift_mag bits, control and mode.
REQ-006 The advance signal SHALL be adv = !out_valid || out_ready, and in_ready SHALL equal adv combinationally.
REQ-007 A transfer SHALL occur when in_valid && in_ready; when adv is 0, all stages SHALL hold their contents unchanged.
REQ-008 Latency SHALL be exactly SHW cycles from an input transfer to out_valid, when no backpressure is applied.
REQ-009 Throughput SHALL be one result per cycle while out_ready is held at 1.
REQ-010 When adv is 1 and in_valid is 0, a bubble (valid bit = 0) SHALL enter stage 0.
REQ-011 Logical mode SHALL zero-fill in both directions.
REQ-012 Arithmetic mode with control=1 SHALL replicate the MSB of the operand; arithmetic mode with control=0 SHALL equal logical left.
REQ-013 Rotate mode SHALL wrap the bits shifted out back into the vacated positions.
REQ-014 Mode 11 SHALL behave as logical.
REQ-015 A shift_mag of 0 SHALL pass in_data through unchanged in every mode.
REQ-016 The result SHALL always be truncated to WIDTH bits; no carry or overflow output is produced.
REQ-017 out_zero SHALL be registered with out_data and SHALL be valid only while out_valid is 1.
REQ-018 out_data SHALL hold stable while out_valid && !out_ready.

Reset
REQ-019 While rst_n is 0, all stage valid bits, out_valid, out_data and out_zero SHALL be 0, and in_ready SHALL be 1.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight words.
REQ-021 No result SHALL appear for discarded words after rst_n is released.
REQ-022 The first transfer after reset SHALL be accepted on the first rising edge at which rst_n is 1.

Configuration
REQ-023 With BARREL_ROTATE_EN defined, mode 10 SHALL rotate as in REQ-013.
REQ-024 Without BARREL_ROTATE_EN, mode 10 SHALL behave as logical, and no rotate wrap logic SHALL be synthesised.

Structure
REQ-025 The package barrel_shift_pkg SHALL hold the mode encodings MODE_LOG, MODE_ARI, MODE_ROT and MODE_RSV, and the direction constants DIR_LEFT and DIR_RIGHT.
REQ-026 One stage SHALL be the sub-module barrel_shift_stage, with parameters WIDTH and AMT (AMT = 2^k).
REQ-027 barrel_shift_stage SHALL contain the combinational fixed-shift mux plus its stage register with hold enable.
REQ-028 The top level SHALL instantiate barrel_shift_stage SHW times with a generate loop.

Verification (WIDTH=8, BARREL_ROTATE_EN defined, out_ready=1 unless stated)
REQ-029 Logical left: 0x7C, shift 2, control 0, mode 00 -> 0xF0 after 3 cycles; 0x34, shift 3 -> 0xA0.
REQ-030 Logical right: 0x64, shift 1, control 1 -> 0x32; 0x31, shift 3 -> 0x06; 0x0E, shift 0 -> 0x0E.
REQ-031 Arithmetic right: 0x80, shift 3, control 1, mode 01 -> 0xF0; 0x40, shift 3 -> 0x08.
REQ-032 Rotate right: 0x31, shift 3, control 1, mode 10 -> 0x26; without the macro the same stimulus -> 0x06.
REQ-033 Backpressure: stream 5 words back-to-back, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 and out_data stable during the stall; all 5 results arrive in order with none lost or duplicated.
REQ-034 Reset with 2 words in flight -> out_valid=0 and no stale output afterwards; 0x01 shifted left 7 -> out_data=0x80 with out_zero=0; 0x01 shifted right 1 -> out_zero=1.
